// File: rtl/nested_ifs_array.sv
// nested_ifs_array
// ----------------
// Per-slot state machine array. Each accepted packet reads one state slot,
// evaluates three configurable predicates on it, and picks one of four
// configurable updates through a nested if/else tree:
//   P0 ? (P1 ? update0 : update1) : (P2 ? update2 : update3)
// The chosen update is written back to the slot, and the before/after values
// are reported on the out_* strobe.
//
// Pipeline: stage 1 registers the packet, its configuration and the slot
// value. Stage 2 computes the result from those registers and, at the end of
// its cycle, writes the slot and loads out_*.
//
// Build option: NESTED_IFS_ARRAY_BYPASS_EN
//   defined   - a packet hitting the slot being written in stage 2 takes the
//               stage-2 result as its slot value (forwarding), never stalls.
//   undefined - that packet is held off (in_ready low) for one cycle and
//               reads the already-updated slot.
//   Both builds produce identical results; only timing differs.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        packet handshake; a packet transfers at a posedge
//                            where both are 1. The sender holds the packet and
//                            its cfg_* stable until it transfers. in_ready is 0
//                            during reset.
//   in_idx, pkt_1, pkt_2     slot index and packet fields
//   cfg_cons                 constants c1..c11, ck at [k*WIDTH-1:(k-1)*WIDTH]
//   cfg_pred_sel             predicate p: {sub_sel, add_sel, zero_sel}
//   cfg_rel_op               predicate p: 0 !=, 1 <, 2 >, 3 == (unsigned)
//   cfg_upd_sel              update u: {sub_sel[1:0], add_sel[1:0], zero_sel}
//   out_valid                single-cycle result strobe, no backpressure
//   out_idx, out_read, out_write  slot, value before and after the update
module nested_ifs_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic [WIDTH-1:0]       pkt_1,
  input  logic [WIDTH-1:0]       pkt_2,
  input  logic [11*WIDTH-1:0]    cfg_cons,
  input  logic [8:0]             cfg_pred_sel,
  input  logic [5:0]             cfg_rel_op,
  input  logic [19:0]            cfg_upd_sel,
  output logic                   out_valid,
  output logic [IDX_W-1:0]       out_idx,
  output logic [WIDTH-1:0]       out_read,
  output logic [WIDTH-1:0]       out_write
);

  logic [WIDTH-1:0] state [DEPTH];

  // stage 1 registers
  logic                s1_valid;
  logic [IDX_W-1:0]    s1_idx;
  logic [WIDTH-1:0]    s1_p1;
  logic [WIDTH-1:0]    s1_p2;
  logic [WIDTH-1:0]    s1_s;
  logic [11*WIDTH-1:0] s1_cons;
  logic [8:0]          s1_pred_sel;
  logic [5:0]          s1_rel_op;
  logic [19:0]         s1_upd_sel;

  // stage 2 combinational datapath
  logic [WIDTH-1:0] cns    [11];
  logic [WIDTH-1:0] pred_k [3];
  logic [WIDTH-1:0] pa     [3];
  logic [WIDTH-1:0] pb     [3];
  logic [WIDTH-1:0] pt     [3];
  logic             pred   [3];
  logic [WIDTH-1:0] ua     [4];
  logic [WIDTH-1:0] ub     [4];
  logic [WIDTH-1:0] ut     [4];
  logic [WIDTH-1:0] result;

  logic             hazard;
  logic             accept;
  logic [WIDTH-1:0] read_value;

  function automatic logic [WIDTH-1:0] term(input logic zero_sel,
                                            input logic [WIDTH-1:0] s,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    return (zero_sel ? '0 : s) + a - b;
  endfunction

  function automatic logic [WIDTH-1:0] mux3(input logic [1:0] sel,
                                            input logic [WIDTH-1:0] p1,
                                            input logic [WIDTH-1:0] p2,
                                            input logic [WIDTH-1:0] k);
    logic [WIDTH-1:0] r;
    case (sel)
      2'd0:    r = p1;
      2'd1:    r = p2;
      default: r = k;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int k = 0; k < 11; k++) begin
      cns[k] = s1_cons[k*WIDTH +: WIDTH];
    end
    // predicates compare against c1, c2 and c7
    pred_k[0] = cns[0];
    pred_k[1] = cns[1];
    pred_k[2] = cns[6];
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      pa[p] = s1_pred_sel[3*p+1] ? s1_p2 : s1_p1;
      pb[p] = s1_pred_sel[3*p+2] ? s1_p2 : s1_p1;
      pt[p] = term(s1_pred_sel[3*p], s1_s, pa[p], pb[p]);
      case (s1_rel_op[2*p +: 2])
        2'd0:    pred[p] = (pt[p] != pred_k[p]);
        2'd1:    pred[p] = (pt[p] <  pred_k[p]);
        2'd2:    pred[p] = (pt[p] >  pred_k[p]);
        default: pred[p] = (pt[p] == pred_k[p]);
      endcase
    end
  end

  // update constants (add, sub): (c3,c4) (c5,c6) (c8,c9) (c10,c11)
  always_comb begin
    ua[0] = mux3(s1_upd_sel[2:1],   s1_p1, s1_p2, cns[2]);
    ub[0] = mux3(s1_upd_sel[4:3],   s1_p1, s1_p2, cns[3]);
    ua[1] = mux3(s1_upd_sel[7:6],   s1_p1, s1_p2, cns[4]);
    ub[1] = mux3(s1_upd_sel[9:8],   s1_p1, s1_p2, cns[5]);
    ua[2] = mux3(s1_upd_sel[12:11], s1_p1, s1_p2, cns[7]);
    ub[2] = mux3(s1_upd_sel[14:13], s1_p1, s1_p2, cns[8]);
    ua[3] = mux3(s1_upd_sel[17:16], s1_p1, s1_p2, cns[9]);
    ub[3] = mux3(s1_upd_sel[19:18], s1_p1, s1_p2, cns[10]);
    for (int u = 0; u < 4; u++) begin
      ut[u] = term(s1_upd_sel[5*u], s1_s, ua[u], ub[u]);
    end
  end

  always_comb begin
    result = ut[3];
    if (pred[0]) begin
      if (pred[1]) result = ut[0];
      else         result = ut[1];
    end else begin
      if (pred[2]) result = ut[2];
      else         result = ut[3];
    end
  end

  // A new packet for the slot stage 2 is about to write would otherwise read
  // the stale array value.
  assign hazard = s1_valid && (s1_idx == in_idx);

`ifdef NESTED_IFS_ARRAY_BYPASS_EN
  assign in_ready   = rst_n;
  assign read_value = hazard ? result : state[in_idx];
`else
  assign in_ready   = rst_n && !hazard;
  assign read_value = state[in_idx];
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= '0;
      end
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_read  <= '0;
      out_write <= '0;
    end else begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (accept) begin
        s1_idx      <= in_idx;
        s1_p1       <= pkt_1;
        s1_p2       <= pkt_2;
        s1_s        <= read_value;
        s1_cons     <= cfg_cons;
        s1_pred_sel <= cfg_pred_sel;
        s1_rel_op   <= cfg_rel_op;
        s1_upd_sel  <= cfg_upd_sel;
      end
      if (s1_valid) begin
        state[s1_idx] <= result;
        out_idx       <= s1_idx;
        out_read      <= s1_s;
        out_write     <= result;
      end
    end
  end

endmodule

// File: tb/tb_nested_ifs_array.sv
// Testbench for nested_ifs_array. A behavioural model applies each accepted
// packet to a slot array in acceptance order and queues the expected result
// with its acceptance edge; a compare process checks the outputs every cycle.
// Directed tests also pin literal values.
module tb_nested_ifs_array;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                in_valid;
  logic                in_ready;
  logic [IDX_W-1:0]    in_idx;
  logic [WIDTH-1:0]    pkt_1;
  logic [WIDTH-1:0]    pkt_2;
  logic [11*WIDTH-1:0] cfg_cons;
  logic [8:0]          cfg_pred_sel;
  logic [5:0]          cfg_rel_op;
  logic [19:0]         cfg_upd_sel;
  logic                out_valid;
  logic [IDX_W-1:0]    out_idx;
  logic [WIDTH-1:0]    out_read;
  logic [WIDTH-1:0]    out_write;

  nested_ifs_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .pkt_1(pkt_1), .pkt_2(pkt_2),
    .cfg_cons(cfg_cons), .cfg_pred_sel(cfg_pred_sel),
    .cfg_rel_op(cfg_rel_op), .cfg_upd_sel(cfg_upd_sel),
    .out_valid(out_valid), .out_idx(out_idx),
    .out_read(out_read), .out_write(out_write)
  );

  // configuration in readable form: cst[k-1] is ck
  logic [WIDTH-1:0] cst  [11];
  logic [2:0]       psel [3];
  logic [1:0]       pop  [3];
  logic [4:0]       usel [4];

  always_comb begin
    for (int k = 0; k < 11; k++) cfg_cons[k*WIDTH +: WIDTH] = cst[k];
    for (int p = 0; p < 3; p++) begin
      cfg_pred_sel[3*p +: 3] = psel[p];
      cfg_rel_op[2*p +: 2]   = pop[p];
    end
    for (int u = 0; u < 4; u++) cfg_upd_sel[5*u +: 5] = usel[u];
  end

  // scoreboard
  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] wr;
    int               acc;
  } exp_t;
  exp_t             exp_q[$];
  logic [WIDTH-1:0] mstate [DEPTH];
  logic [WIDTH-1:0] obs_r[$];
  logic [WIDTH-1:0] obs_w[$];
  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int rst_edge = -1;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string name, input bit use_w, input int i,
                         input logic [WIDTH-1:0] exp);
    int sz;
    sz = use_w ? obs_w.size() : obs_r.size();
    if (i >= sz) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: result %0d missing (only %0d seen), expected %0h", name, i, sz, exp);
    end else begin
      chk(name, use_w ? obs_w[i] : obs_r[i], exp);
    end
  endtask

  // Model: the slot goes through the selected update in acceptance order.
  function automatic logic [WIDTH-1:0] opnd(input logic [1:0] sel,
                                            input logic [WIDTH-1:0] k);
    if (sel == 2'd0) return pkt_1;
    if (sel == 2'd1) return pkt_2;
    return k;
  endfunction

  task automatic model_accept();
    logic [WIDTH-1:0] s, a, b, t, w, k;
    bit pr[3];
    int u;
    int kadd[4];
    kadd = '{2, 4, 7, 9};
    s = mstate[in_idx];
    for (int p = 0; p < 3; p++) begin
      k = (p == 0) ? cst[0] : (p == 1) ? cst[1] : cst[6];
      a = psel[p][1] ? pkt_2 : pkt_1;
      b = psel[p][2] ? pkt_2 : pkt_1;
      t = (psel[p][0] ? '0 : s) + a - b;
      case (pop[p])
        2'd0: pr[p] = (t != k);
        2'd1: pr[p] = (t < k);
        2'd2: pr[p] = (t > k);
        default: pr[p] = (t == k);
      endcase
    end
    u = pr[0] ? (pr[1] ? 0 : 1) : (pr[2] ? 2 : 3);
    a = opnd(usel[u][2:1], cst[kadd[u]]);
    b = opnd(usel[u][4:3], cst[kadd[u] + 1]);
    w = (usel[u][0] ? '0 : s) + a - b;
    mstate[in_idx] = w;
    exp_q.push_back('{in_idx, s, w, edge_cnt + 1});
  endtask

  always @(posedge clk) edge_cnt++;

  // acceptance / reset monitor, just before the active edge
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      chk("in_ready_during_reset", WIDTH'(in_ready), '0);
      for (int i = 0; i < DEPTH; i++) mstate[i] = '0;
      exp_q.delete();
      rst_edge = edge_cnt + 1;
    end else if (in_valid && in_ready) begin
      model_accept();
    end
  end

  // compare process: outputs sampled on the falling edge
  bit   exp_v;
  exp_t e;
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      if (rst_edge == edge_cnt) begin
        started = 1'b1;
        chk("reset_out_valid", WIDTH'(out_valid), '0);
        chk("reset_out_idx",   WIDTH'(out_idx),   '0);
        chk("reset_out_read",  out_read,          '0);
        chk("reset_out_write", out_write,         '0);
      end else if (started) begin
        exp_v = (exp_q.size() > 0) && (exp_q[0].acc == edge_cnt - 1);
        chk("out_valid", WIDTH'(out_valid), WIDTH'(exp_v));
        if (exp_v) begin
          e = exp_q.pop_front();
          if (out_valid) begin
            chk("out_idx",   WIDTH'(out_idx), WIDTH'(e.idx));
            chk("out_read",  out_read,  e.rd);
            chk("out_write", out_write, e.wr);
            obs_r.push_back(out_read);
            obs_w.push_back(out_write);
          end
        end
      end
    end
  end

  // driver tasks; all start and end 1 time unit after a falling edge
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, inout int stalls);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    in_idx = idx;
    pkt_1 = a;
    pkt_2 = b;
    in_valid = 1'b1;
    while (!done) begin
      #3;
      if (in_ready) done = 1'b1;
      else begin
        stalls++;
        waited++;
      end
      @(negedge clk);
      #1;
      if (!done && waited > 20) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: idx %0d not accepted after %0d cycles, expected within 20", idx, waited);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // c1/c2/c7 = 99 with op != on the raw slot value: P0 and P1 true.
  // update0 S+pkt_1-c4, update1 c5-pkt_2, update2 S+pkt_2-pkt_1, update3 c10-c11
  task automatic set_base();
    cst = '{32'd99, 32'd99, 32'd0, 32'd0, 32'd1000, 32'd0, 32'd99,
            32'd0, 32'd0, 32'd500, 32'd7};
    psel = '{3'b000, 3'b000, 3'b000};
    pop  = '{2'd0, 2'd0, 2'd0};
    usel = '{5'b10000, 5'b01101, 5'b00010, 5'b10101};
  endtask

  int stalls;
  int exp_stalls;

  initial begin
    in_valid = 1'b0;
    in_idx = '0;
    pkt_1 = '0;
    pkt_2 = '0;
    set_base();
    @(negedge clk);
    #1;
    apply_reset(2);

    // single packet to idx 3
    obs_r.delete(); obs_w.delete(); stalls = 0;
    send(4'd3, 32'd5, 32'd0, stalls);
    idle(4);
    chk_obs("single_read", 1'b0, 0, 32'd0);
    chk_obs("single_write", 1'b1, 0, 32'd5);

    // four back-to-back packets to the same slot
    apply_reset(1);
    obs_r.delete(); obs_w.delete(); stalls = 0;
    for (int i = 0; i < 4; i++) send(4'd3, 32'd5, 32'd0, stalls);
    idle(4);
    for (int i = 0; i < 4; i++) chk_obs("same_idx_write", 1'b1, i, WIDTH'(5 * (i + 1)));
`ifdef NESTED_IFS_ARRAY_BYPASS_EN
    exp_stalls = 0;
`else
    exp_stalls = 3;
`endif
    chk("same_idx_stalls", WIDTH'(stalls), WIDTH'(exp_stalls));

    // alternating slots never stall
    obs_r.delete(); obs_w.delete(); stalls = 0;
    for (int i = 0; i < 4; i++) begin
      send(4'd1, 32'd1, 32'd0, stalls);
      send(4'd2, 32'd2, 32'd0, stalls);
    end
    idle(4);
    for (int i = 0; i < 8; i++)
      chk_obs("alt_idx_write", 1'b1, i, WIDTH'((i / 2 + 1) * (i % 2 + 1)));
    chk("alt_idx_stalls", WIDTH'(stalls), '0);

    // wrap-around, then predicate '<' against c1=1 on the wrapped value
    obs_r.delete(); obs_w.delete(); stalls = 0;
    send(4'd5, 32'hFFFF_FFFF, 32'd0, stalls);
    send(4'd5, 32'd1, 32'd0, stalls);
    pop[0] = 2'd1;
    cst[0] = 32'd1;
    send(4'd5, 32'd7, 32'd0, stalls);
    idle(4);
    chk_obs("wrap_max", 1'b1, 0, 32'hFFFF_FFFF);
    chk_obs("wrap_read", 1'b0, 1, 32'hFFFF_FFFF);
    chk_obs("wrap_zero", 1'b1, 1, 32'd0);
    chk_obs("lt_pred_write", 1'b1, 2, 32'd7);

    // walk the four branches; predicates evaluate zero+p1-p1 = 0 against 0
    set_base();
    cst[0] = 32'd0; cst[1] = 32'd0; cst[6] = 32'd0;
    psel = '{3'b001, 3'b001, 3'b001};
    obs_r.delete(); obs_w.delete(); stalls = 0;
    pop = '{2'd3, 2'd3, 2'd0};
    send(4'd7, 32'd3, 32'd10, stalls);
    pop = '{2'd3, 2'd0, 2'd0};
    send(4'd7, 32'd3, 32'd10, stalls);
    pop = '{2'd0, 2'd0, 2'd3};
    send(4'd7, 32'd3, 32'd10, stalls);
    pop = '{2'd0, 2'd0, 2'd0};
    send(4'd7, 32'd3, 32'd10, stalls);
    idle(4);
    chk_obs("branch_u0", 1'b1, 0, 32'd3);
    chk_obs("branch_u1", 1'b1, 1, 32'd990);
    chk_obs("branch_u2", 1'b1, 2, 32'd997);
    chk_obs("branch_u3", 1'b1, 3, 32'd493);

    // reset with packets in flight, then read slots back unchanged (update0, p1=0)
    set_base();
    stalls = 0;
    send(4'd5, 32'd1, 32'd0, stalls);
    send(4'd7, 32'd1, 32'd0, stalls);
    apply_reset(2);
    obs_r.delete(); obs_w.delete();
    send(4'd3, 32'd0, 32'd0, stalls);
    send(4'd5, 32'd0, 32'd0, stalls);
    send(4'd7, 32'd0, 32'd0, stalls);
    idle(4);
    for (int i = 0; i < 3; i++) chk_obs("post_reset_read", 1'b0, i, 32'd0);

    chk("scoreboard_drained", WIDTH'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
